// File: rtl/estado_escritura_alsu_if.sv
// rtl/estado_escritura_alsu_if.sv - ALSU result / register-bank write bundle
//
// Purpose: groups the signals between the ALSU, the write-back stage and the
// Register Bank.
//   slave  : the write-back stage (estado_escritura_alsu)
//   master : the surrounding logic (ALSU side, Register Bank side, flag loader)
// Signals:
//   EntradaValida/EntradaLista        ALSU result handshake
//   Selector, Resultado, Acarreo,     captured ALSU result and operand signs
//   SignoA, SignoB, Destino
//   CargarBanderas/DatoBanderas       direct Status load
//   Vaciar                            synchronous buffer flush
//   EscribirValido/BancoListo,        Register Bank write handshake
//   EscribirDato, EscribirDir
//   Banderas, Ilegal, Ocupacion       status outputs
interface estado_escritura_alsu_if #(
  parameter int ANCHO     = 16,
  parameter int ANCHO_DIR = 3
);
  logic                 EntradaValida;
  logic                 EntradaLista;
  logic [3:0]           Selector;
  logic [ANCHO-1:0]     Resultado;
  logic                 Acarreo;
  logic                 SignoA;
  logic                 SignoB;
  logic [ANCHO_DIR-1:0] Destino;
  logic                 CargarBanderas;
  logic [3:0]           DatoBanderas;
  logic                 Vaciar;
  logic                 EscribirValido;
  logic [ANCHO-1:0]     EscribirDato;
  logic [ANCHO_DIR-1:0] EscribirDir;
  logic                 BancoListo;
  logic [3:0]           Banderas;
  logic                 Ilegal;
  logic [1:0]           Ocupacion;

  modport slave (
    input  EntradaValida, Selector, Resultado, Acarreo, SignoA, SignoB,
           Destino, CargarBanderas, DatoBanderas, Vaciar, BancoListo,
    output EntradaLista, EscribirValido, EscribirDato, EscribirDir,
           Banderas, Ilegal, Ocupacion
  );

  modport master (
    output EntradaValida, Selector, Resultado, Acarreo, SignoA, SignoB,
           Destino, CargarBanderas, DatoBanderas, Vaciar, BancoListo,
    input  EntradaLista, EscribirValido, EscribirDato, EscribirDir,
           Banderas, Ilegal, Ocupacion
  );
endinterface

// File: rtl/estado_escritura_alsu.sv
// rtl/estado_escritura_alsu.sv - ALSU write-back stage: Status flags and 2-entry write buffer
//
// Purpose: captures each ALSU result, derives overflow from the operand sign
// bits, keeps the Status register {Z,N,C,V} and forwards register-writing
// results to the Register Bank through a 2-entry in-order buffer.
// Ports:
//   Reloj  : clock, rising edge
//   Reset  : asynchronous, active-high reset
//   bus    : estado_escritura_alsu_if.slave (ALSU input handshake, flag load,
//            flush, Register Bank write handshake, Banderas/Ilegal/Ocupacion)
// The interface instance must use the same ANCHO/ANCHO_DIR as this module.
module estado_escritura_alsu #(
  parameter int ANCHO     = 16,
  parameter int ANCHO_DIR = 3
) (
  input  logic                    Reloj,
  input  logic                    Reset,
  estado_escritura_alsu_if.slave  bus
);

  // Opcode encoding of the ALSU Selector.
  localparam logic [3:0] OP_DEC  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_INC  = 4'b0111;
  localparam logic [3:0] OP_MOV  = 4'b1000;
  localparam logic [3:0] OP_RES0 = 4'b1001;
  localparam logic [3:0] OP_TEST = 4'b1010;
  localparam logic [3:0] OP_RES1 = 4'b1011;

  // Status bit positions inside Banderas = {Z,N,C,V}.
  localparam int BIT_Z = 3;
  localparam int BIT_N = 2;
  localparam int BIT_C = 1;
  localparam int BIT_V = 0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0]           banderas_q, banderas_d;
  logic                 ilegal_q,   ilegal_d;
  logic [1:0]           ocup_q,     ocup_d;
  logic                 rd_ptr_q,   rd_ptr_d;
  logic                 wr_ptr_q,   wr_ptr_d;
  logic [ANCHO-1:0]     dato_q [2];
  logic [ANCHO_DIR-1:0] dir_q  [2];

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic lista;
  logic acepta;
  logic escribe;
  logic reservado;
  logic push;
  logic pop;
  logic [3:0] banderas_op;

  // Readiness depends only on registered occupancy and the flush request, so a
  // pop from a full buffer cannot be reused for an accept in the same cycle.
  assign lista  = (ocup_q != 2'd2) && !bus.Vaciar;
  assign acepta = bus.EntradaValida && lista;
  assign pop    = (ocup_q != 2'd0) && bus.BancoListo;
  assign push   = acepta && escribe;

  // ---------------------------------------------------------------------------
  // Opcode decode and flag computation
  // ---------------------------------------------------------------------------
  logic z_res;
  logic n_res;

  assign z_res = (bus.Resultado == '0);
  assign n_res = bus.Resultado[ANCHO-1];

  always_comb begin
    banderas_op = banderas_q;
    escribe     = 1'b0;
    reservado   = 1'b0;
    casez (bus.Selector)
      4'b00??: begin
        // NOT/AND/XOR/OR: only the result-derived flags change.
        banderas_op[BIT_Z] = z_res;
        banderas_op[BIT_N] = n_res;
        escribe            = 1'b1;
      end
      OP_DEC: begin
        // Decrementing a negative value into a non-negative one wraps.
        banderas_op[BIT_Z] = z_res;
        banderas_op[BIT_N] = n_res;
        banderas_op[BIT_C] = bus.Acarreo;
        banderas_op[BIT_V] = bus.SignoA & ~n_res;
        escribe            = 1'b1;
      end
      OP_ADD: begin
        banderas_op[BIT_Z] = z_res;
        banderas_op[BIT_N] = n_res;
        banderas_op[BIT_C] = bus.Acarreo;
        banderas_op[BIT_V] = (bus.SignoA == bus.SignoB) && (n_res != bus.SignoA);
        escribe            = 1'b1;
      end
      OP_SUB, OP_TEST: begin
        // TEST is a SUB whose result is discarded.
        banderas_op[BIT_Z] = z_res;
        banderas_op[BIT_N] = n_res;
        banderas_op[BIT_C] = bus.Acarreo;
        banderas_op[BIT_V] = (bus.SignoA != bus.SignoB) && (n_res != bus.SignoA);
        escribe            = (bus.Selector == OP_SUB);
      end
      OP_INC: begin
        // Incrementing a non-negative value into a negative one wraps.
        banderas_op[BIT_Z] = z_res;
        banderas_op[BIT_N] = n_res;
        banderas_op[BIT_C] = bus.Acarreo;
        banderas_op[BIT_V] = ~bus.SignoA & n_res;
        escribe            = 1'b1;
      end
      OP_MOV: begin
        escribe = 1'b1;
      end
      4'b11??: begin
        // Shifts/rotates: the bit shifted out arrives on Acarreo.
        banderas_op[BIT_Z] = z_res;
        banderas_op[BIT_N] = n_res;
        banderas_op[BIT_C] = bus.Acarreo;
        escribe            = 1'b1;
      end
      OP_RES0, OP_RES1: begin
        reservado = 1'b1;
      end
      default: begin
        reservado = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    banderas_d = banderas_q;
    ilegal_d   = 1'b0;
    ocup_d     = ocup_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    // A direct load wins over the flags of a same-cycle accepted op.
    if (bus.CargarBanderas) begin
      banderas_d = bus.DatoBanderas;
    end else if (acepta) begin
      banderas_d = banderas_op;
    end

    ilegal_d = acepta && reservado;

    if (bus.Vaciar) begin
      ocup_d   = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      ocup_d   = ocup_q + 2'(push) - 2'(pop);
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
    end
  end

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      banderas_q <= 4'b0000;
      ilegal_q   <= 1'b0;
      ocup_q     <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      banderas_q <= banderas_d;
      ilegal_q   <= ilegal_d;
      ocup_q     <= ocup_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage; cleared on reset so the write port idles at zero.
  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      dato_q[0] <= '0;
      dato_q[1] <= '0;
      dir_q[0]  <= '0;
      dir_q[1]  <= '0;
    end else if (push) begin
      dato_q[wr_ptr_q] <= bus.Resultado;
      dir_q[wr_ptr_q]  <= bus.Destino;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.EntradaLista   = lista;
  assign bus.EscribirValido = (ocup_q != 2'd0);
  assign bus.EscribirDato   = dato_q[rd_ptr_q];
  assign bus.EscribirDir    = dir_q[rd_ptr_q];
  assign bus.Banderas       = banderas_q;
  assign bus.Ilegal         = ilegal_q;
  assign bus.Ocupacion      = ocup_q;

endmodule

// File: tb/tb_estado_escritura_alsu.sv
// tb/tb_estado_escritura_alsu.sv - self-checking bench for estado_escritura_alsu
module tb_estado_escritura_alsu;

  localparam int ANCHO     = 16;
  localparam int ANCHO_DIR = 3;

  logic Reloj;
  logic Reset;

  estado_escritura_alsu_if #(.ANCHO(ANCHO), .ANCHO_DIR(ANCHO_DIR)) bus ();

  estado_escritura_alsu #(.ANCHO(ANCHO), .ANCHO_DIR(ANCHO_DIR)) dut (
    .Reloj (Reloj),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Reloj = 1'b0;
  always #5 Reloj = ~Reloj;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard of expected writes {dir, dato}, oldest first.
  logic [ANCHO_DIR+ANCHO-1:0] esperado [$];
  logic [3:0] flags_exp  = 4'b0000;
  logic       ilegal_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: returns {writes, reserved, new flags}.
  function automatic logic [5:0] modelo(input logic [3:0] sel, input logic [15:0] r,
                                        input logic c, input logic sa, input logic sbb,
                                        input logic [3:0] f);
    logic z, n, cc, v, wr, rs;
    z = (r == 16'h0000);
    n = r[15];
    cc = f[1];
    v  = f[0];
    wr = 1'b1;
    rs = 1'b0;
    if (sel <= 4'd3) begin
      // flags Z,N only
    end else if (sel == 4'd4) begin
      cc = c; v = sa & ~n;
    end else if (sel == 4'd5) begin
      cc = c; v = (sa == sbb) && (n != sa);
    end else if (sel == 4'd6 || sel == 4'd10) begin
      cc = c; v = (sa != sbb) && (n != sa);
      if (sel == 4'd10) wr = 1'b0;
    end else if (sel == 4'd7) begin
      cc = c; v = ~sa & n;
    end else if (sel >= 4'd12) begin
      cc = c;
    end else if (sel == 4'd8) begin
      return {1'b1, 1'b0, f};
    end else begin
      return {1'b0, 1'b1, f};
    end
    return {wr, rs, z, n, cc, v};
  endfunction

  // One clock cycle; entered just after a falling edge with inputs already set.
  task automatic ciclo();
    logic       lista_exp, acc, hace_pop;
    logic [5:0] m;
    #3;
    lista_exp = (esperado.size() < 2) && !bus.Vaciar;
    check("lista", 32'(bus.EntradaLista), 32'(lista_exp));
    check("ocupacion", 32'(bus.Ocupacion), 32'(esperado.size()));
    check("valido", 32'(bus.EscribirValido), 32'(esperado.size() != 0));
    if (esperado.size() != 0) begin
      check("dato", 32'(bus.EscribirDato), 32'(esperado[0][ANCHO-1:0]));
      check("dir", 32'(bus.EscribirDir), 32'(esperado[0][ANCHO+ANCHO_DIR-1:ANCHO]));
    end
    hace_pop = (esperado.size() != 0) && bus.BancoListo;
    acc = bus.EntradaValida && lista_exp;
    m = modelo(bus.Selector, bus.Resultado, bus.Acarreo, bus.SignoA, bus.SignoB, flags_exp);
    @(posedge Reloj);
    if (hace_pop) void'(esperado.pop_front());
    if (bus.Vaciar) esperado.delete();
    if (acc && m[5]) esperado.push_back({bus.Destino, bus.Resultado});
    if (bus.CargarBanderas) flags_exp = bus.DatoBanderas;
    else if (acc) flags_exp = m[3:0];
    ilegal_exp = acc && m[4];
    @(negedge Reloj);
    check("banderas", 32'(bus.Banderas), 32'(flags_exp));
    check("ilegal", 32'(bus.Ilegal), 32'(ilegal_exp));
  endtask

  task automatic op(input logic [3:0] sel, input logic [15:0] r, input logic c,
                    input logic sa, input logic sbb, input logic [2:0] dir);
    bus.Selector      = sel;
    bus.Resultado     = r;
    bus.Acarreo       = c;
    bus.SignoA        = sa;
    bus.SignoB        = sbb;
    bus.Destino       = dir;
    bus.EntradaValida = 1'b1;
    ciclo();
    bus.EntradaValida = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset              = 1'b1;
    bus.EntradaValida  = 1'b0;
    bus.Selector       = 4'h0;
    bus.Resultado      = 16'h0000;
    bus.Acarreo        = 1'b0;
    bus.SignoA         = 1'b0;
    bus.SignoB         = 1'b0;
    bus.Destino        = 3'd0;
    bus.CargarBanderas = 1'b0;
    bus.DatoBanderas   = 4'h0;
    bus.Vaciar         = 1'b0;
    bus.BancoListo     = 1'b1;

    // Reset state
    #12;
    check("rst_banderas", 32'(bus.Banderas), 32'h0);
    check("rst_ocupacion", 32'(bus.Ocupacion), 32'h0);
    check("rst_valido", 32'(bus.EscribirValido), 32'h0);
    check("rst_dato", 32'(bus.EscribirDato), 32'h0);
    check("rst_dir", 32'(bus.EscribirDir), 32'h0);
    check("rst_ilegal", 32'(bus.Ilegal), 32'h0);
    check("rst_lista", 32'(bus.EntradaLista), 32'h1);
    @(negedge Reloj);
    Reset = 1'b0;
    ciclo();

    // ADD overflowing into the sign bit
    op(4'b0101, 16'h8000, 1'b0, 1'b0, 1'b0, 3'd3);
    check("add_flags", 32'(bus.Banderas), 32'b0101);
    check("add_valido", 32'(bus.EscribirValido), 32'h1);
    check("add_dato", 32'(bus.EscribirDato), 32'h8000);
    ciclo();

    // SUB to zero, then TEST (no write)
    op(4'b0110, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd4);
    check("sub_flags", 32'(bus.Banderas), 32'b1000);
    ciclo();
    op(4'b1010, 16'hFFFF, 1'b1, 1'b0, 1'b0, 3'd5);
    check("test_flags", 32'(bus.Banderas), 32'b0110);
    check("test_nowrite", 32'(bus.EscribirValido), 32'h0);

    // Stall with a full buffer, then drain
    bus.BancoListo = 1'b0;
    op(4'b1000, 16'h1111, 1'b0, 1'b0, 1'b0, 3'd1);
    op(4'b1000, 16'h2222, 1'b0, 1'b0, 1'b0, 3'd2);
    check("full_ocup", 32'(bus.Ocupacion), 32'd2);
    check("full_lista", 32'(bus.EntradaLista), 32'h0);
    op(4'b1000, 16'h3333, 1'b0, 1'b0, 1'b0, 3'd3);
    ciclo();
    check("stall_dir", 32'(bus.EscribirDir), 32'd1);
    bus.BancoListo = 1'b1;
    op(4'b1000, 16'h4444, 1'b0, 1'b0, 1'b0, 3'd4);
    check("drain_dir2", 32'(bus.EscribirDir), 32'd2);
    ciclo();
    ciclo();

    // Reserved opcode
    op(4'b1001, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd6);
    check("res_ilegal", 32'(bus.Ilegal), 32'h1);
    check("res_ocup", 32'(bus.Ocupacion), 32'h0);
    ciclo();
    check("res_pulse", 32'(bus.Ilegal), 32'h0);

    // Direct flag load beats INC flags; INC still written
    bus.CargarBanderas = 1'b1;
    bus.DatoBanderas   = 4'b1010;
    op(4'b0111, 16'h8000, 1'b0, 1'b0, 1'b0, 3'd7);
    bus.CargarBanderas = 1'b0;
    check("load_flags", 32'(bus.Banderas), 32'b1010);
    check("load_dato", 32'(bus.EscribirDato), 32'h8000);
    ciclo();

    // Back-to-back randomised traffic
    for (int i = 0; i < 60; i++) begin
      bus.BancoListo = ($urandom_range(0, 3) != 0);
      bus.Vaciar     = ($urandom_range(0, 9) == 0);
      bus.CargarBanderas = ($urandom_range(0, 9) == 0);
      bus.DatoBanderas   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) != 0)
        op(4'($urandom_range(0, 15)), 16'($urandom()), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      else
        ciclo();
    end
    bus.Vaciar = 1'b0;
    bus.CargarBanderas = 1'b0;
    bus.BancoListo = 1'b1;
    ciclo();
    ciclo();
    ciclo();

    // Asynchronous reset with one buffered write
    bus.BancoListo     = 1'b0;
    bus.CargarBanderas = 1'b1;
    bus.DatoBanderas   = 4'b0110;
    op(4'b1000, 16'h5555, 1'b0, 1'b0, 1'b0, 3'd5);
    bus.CargarBanderas = 1'b0;
    check("pre_rst_ocup", 32'(bus.Ocupacion), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("arst_valido", 32'(bus.EscribirValido), 32'h0);
    check("arst_banderas", 32'(bus.Banderas), 32'h0);
    check("arst_ocup", 32'(bus.Ocupacion), 32'h0);
    esperado.delete();
    flags_exp  = 4'b0000;
    ilegal_exp = 1'b0;
    @(negedge Reloj);
    Reset = 1'b0;
    ciclo();

    // Flush a full buffer
    op(4'b0000, 16'h00AA, 1'b0, 1'b0, 1'b0, 3'd1);
    op(4'b0001, 16'h00BB, 1'b0, 1'b0, 1'b0, 3'd2);
    check("vac_pre", 32'(bus.Ocupacion), 32'd2);
    bus.Vaciar = 1'b1;
    op(4'b0011, 16'h00CC, 1'b0, 1'b0, 1'b0, 3'd3);
    bus.Vaciar = 1'b0;
    check("vac_ocup", 32'(bus.Ocupacion), 32'd0);
    check("vac_valido", 32'(bus.EscribirValido), 32'h0);
    bus.BancoListo = 1'b1;
    ciclo();
    ciclo();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
